// File: rtl/jtag_dbg_pkg.sv
// Shared types and helpers for the JTAG debug data-register bank:
// event priority encoding, per-channel length lookup and length masks.
package jtag_dbg_pkg;

  localparam int CH_LEN_FW = 6;   // bits per packed channel-length field
  localparam int MAX_CH    = 32;  // widest packed length vector ch_len() accepts
  localparam int MAX_DR_W  = 64;  // widest mask len_mask() can produce

  // Encoded in priority order; only the highest qualified strobe acts.
  typedef enum logic [2:0] {
    EV_NONE,
    EV_UPD_IR,
    EV_UPD_DR,
    EV_CAP_DR,
    EV_SHIFT_DR
  } dr_event_e;

  function automatic logic [CH_LEN_FW-1:0] ch_len(
    input logic [CH_LEN_FW*MAX_CH-1:0] lens,
    input int                          idx
  );
    return lens[idx*CH_LEN_FW +: CH_LEN_FW];
  endfunction

  function automatic logic [MAX_DR_W-1:0] len_mask(input logic [CH_LEN_FW-1:0] len);
    return (MAX_DR_W'(1) << len) - MAX_DR_W'(1);
  endfunction

endpackage

// File: rtl/jtag_dbg_update_slot.sv
// One-entry valid/ready buffer between the DR bank and the CPU-side debug logic.
// A write into a full, non-draining slot is dropped and raises sticky overrun.
module jtag_dbg_update_slot #(
  parameter int DR_W = 38,
  parameter int IR_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [DR_W-1:0] wr_data,
  input  logic [IR_W-1:0] wr_ch,
  input  logic            err_clr,
  input  logic            upd_ready,
  output logic            upd_valid,
  output logic [DR_W-1:0] upd_data,
  output logic [IR_W-1:0] upd_ch,
  output logic            overrun
);

  logic            valid_q,   valid_d;
  logic [DR_W-1:0] data_q,    data_d;
  logic [IR_W-1:0] ch_q,      ch_d;
  logic            overrun_q, overrun_d;
  logic            drain;
  logic            ovr_set;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ovr_set = 1'b0;
    drain   = valid_q && upd_ready;

    if (wr_en) begin
      if (!valid_q || drain) begin
        valid_d = 1'b1;
        data_d  = wr_data;
        ch_d    = wr_ch;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (drain) begin
      valid_d = 1'b0;
    end

    // A new overrun in the same cycle as err_clr keeps the flag set.
    if (ovr_set)      overrun_d = 1'b1;
    else if (err_clr) overrun_d = 1'b0;
    else              overrun_d = overrun_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      ch_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      ch_q      <= ch_d;
      overrun_q <= overrun_d;
    end
  end

  assign upd_valid = valid_q;
  assign upd_data  = data_q;
  assign upd_ch    = ch_q;
  assign overrun   = overrun_q;

endmodule

// File: rtl/jtag_debug_dr_bank.sv
// Parametrised JTAG debug DR bank in the system clock domain: IR-selected
// capture/shift/update of per-channel-length DRs, feeding an update slot.
module jtag_debug_dr_bank
  import jtag_dbg_pkg::*;
#(
  parameter int                            IR_W   = 2,
  parameter int                            NUM_CH = 4,
  parameter int                            DR_W   = 38,
  parameter logic [NUM_CH*CH_LEN_FW-1:0]   CH_LEN = {6'd16, 6'd38, 6'd38, 6'd36},
  parameter int                            CNT_W  = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sel,
  input  logic                   sel_ir,
  input  logic                   capture_dr,
  input  logic                   shift_dr,
  input  logic                   update_dr,
  input  logic                   update_ir,
  input  logic [IR_W-1:0]        ir_in,
  input  logic                   tdi,
  output logic                   tdo,
  input  logic [NUM_CH*DR_W-1:0] cap_data,
  input  logic [IR_W-1:0]        status_in,
  output logic [IR_W-1:0]        ir_out,
  output logic [IR_W-1:0]        ir,
  output logic                   upd_valid,
  input  logic                   upd_ready,
  output logic [DR_W-1:0]        upd_data,
  output logic [IR_W-1:0]        upd_ch,
  output logic                   overrun,
  output logic                   len_err,
  input  logic                   err_clr
);

  localparam logic [CH_LEN_FW*MAX_CH-1:0] CH_LEN_EXT  = (CH_LEN_FW*MAX_CH)'(CH_LEN);
  localparam logic [IR_W:0]               NUM_CH_CMP  = (IR_W+1)'(NUM_CH);

  logic [DR_W-1:0]      sr_q,         sr_d;
  logic [IR_W-1:0]      ir_q,         ir_d;
  logic [IR_W-1:0]      ir_out_q,     ir_out_d;
  logic [CNT_W-1:0]     shift_cnt_q,  shift_cnt_d;
  logic                 in_between_q, in_between_d;
  logic                 len_err_q,    len_err_d;

  dr_event_e            ev;
  logic                 is_bypass;
  logic [CH_LEN_FW-1:0] eff_len;
  logic [DR_W-1:0]      mask;
  logic [DR_W-1:0]      cap_sel;
  logic                 cnt_match;
  logic                 slot_wr;
  logic                 len_err_set;

  always_comb begin
    if (update_ir && sel_ir)   ev = EV_UPD_IR;
    else if (update_dr && sel) ev = EV_UPD_DR;
    else if (capture_dr && sel) ev = EV_CAP_DR;
    else if (shift_dr && sel)  ev = EV_SHIFT_DR;
    else                       ev = EV_NONE;

    is_bypass = ({1'b0, ir_q} >= NUM_CH_CMP);
    eff_len   = is_bypass ? CH_LEN_FW'(1) : ch_len(CH_LEN_EXT, int'(ir_q));
    mask      = DR_W'(len_mask(eff_len));
    cnt_match = (shift_cnt_q == CNT_W'(eff_len));

    cap_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ir_q == IR_W'(c)) cap_sel = cap_data[c*DR_W +: DR_W];
    end
  end

  always_comb begin
    sr_d         = sr_q;
    ir_d         = ir_q;
    shift_cnt_d  = shift_cnt_q;
    in_between_d = in_between_q;
    slot_wr      = 1'b0;
    len_err_set  = 1'b0;
    ir_out_d     = (sel_ir && capture_dr) ? status_in : ir_out_q;

    case (ev)
      EV_UPD_IR: begin
        ir_d         = ir_in;
        in_between_d = 1'b0;
        shift_cnt_d  = '0;
      end
      EV_UPD_DR: begin
        in_between_d = 1'b0;
        if (!is_bypass) begin
          if (cnt_match) slot_wr     = 1'b1;
          else           len_err_set = 1'b1;
        end
      end
      EV_CAP_DR: begin
        // A capture between shift bursts of one scan keeps the bits already shifted in.
        shift_cnt_d = '0;
        if (!in_between_q) sr_d = is_bypass ? '0 : (cap_sel & mask);
      end
      EV_SHIFT_DR: begin
        sr_d         = ((sr_q >> 1) | (DR_W'(tdi) << (eff_len - CH_LEN_FW'(1)))) & mask;
        shift_cnt_d  = (shift_cnt_q == '1) ? shift_cnt_q : shift_cnt_q + CNT_W'(1);
        in_between_d = 1'b1;
      end
      default: ;
    endcase

    if (len_err_set)  len_err_d = 1'b1;
    else if (err_clr) len_err_d = 1'b0;
    else              len_err_d = len_err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q         <= '0;
      ir_q         <= '0;
      ir_out_q     <= '0;
      shift_cnt_q  <= '0;
      in_between_q <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      ir_q         <= ir_d;
      ir_out_q     <= ir_out_d;
      shift_cnt_q  <= shift_cnt_d;
      in_between_q <= in_between_d;
      len_err_q    <= len_err_d;
    end
  end

  jtag_dbg_update_slot #(
    .DR_W (DR_W),
    .IR_W (IR_W)
  ) u_slot (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (slot_wr),
    .wr_data   (sr_q),
    .wr_ch     (ir_q),
    .err_clr   (err_clr),
    .upd_ready (upd_ready),
    .upd_valid (upd_valid),
    .upd_data  (upd_data),
    .upd_ch    (upd_ch),
    .overrun   (overrun)
  );

  assign tdo     = sr_q[0];
  assign ir      = ir_q;
  assign ir_out  = ir_out_q;
  assign len_err = len_err_q;

endmodule

// File: tb/tb_jtag_debug_dr_bank.sv
// Directed bench for jtag_debug_dr_bank with three channels (lengths 16/38/36)
// so IR code 3 exercises bypass.
module tb_jtag_debug_dr_bank;

  localparam int IR_W   = 2;
  localparam int NUM_CH = 3;
  localparam int DR_W   = 38;
  localparam int CNT_W  = 7;
  localparam logic [NUM_CH*6-1:0] CH_LEN = {6'd36, 6'd38, 6'd16};

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   sel, sel_ir;
  logic                   capture_dr, shift_dr, update_dr, update_ir;
  logic [IR_W-1:0]        ir_in;
  logic                   tdi;
  logic                   tdo;
  logic [NUM_CH*DR_W-1:0] cap_data;
  logic [IR_W-1:0]        status_in;
  logic [IR_W-1:0]        ir_out;
  logic [IR_W-1:0]        ir;
  logic                   upd_valid;
  logic                   upd_ready;
  logic [DR_W-1:0]        upd_data;
  logic [IR_W-1:0]        upd_ch;
  logic                   overrun;
  logic                   len_err;
  logic                   err_clr;

  int tests = 0;
  int fails = 0;

  localparam logic [DR_W-1:0] CAP0 = {22'h3F_FFFF, 16'hA5C3};
  localparam logic [DR_W-1:0] CAP1 = 38'h2_1234_5678;
  localparam logic [DR_W-1:0] CAP2 = 38'h15_5555_5555;

  jtag_debug_dr_bank #(
    .IR_W   (IR_W),
    .NUM_CH (NUM_CH),
    .DR_W   (DR_W),
    .CH_LEN (CH_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .sel_ir     (sel_ir),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .update_ir  (update_ir),
    .ir_in      (ir_in),
    .tdi        (tdi),
    .tdo        (tdo),
    .cap_data   (cap_data),
    .status_in  (status_in),
    .ir_out     (ir_out),
    .ir         (ir),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_data   (upd_data),
    .upd_ch     (upd_ch),
    .overrun    (overrun),
    .len_err    (len_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ir(input logic [IR_W-1:0] code);
    sel = 1'b0; sel_ir = 1'b1; ir_in = code; update_ir = 1'b1;
    tick();
    update_ir = 1'b0; sel_ir = 1'b0; sel = 1'b1;
  endtask

  task automatic capture();
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
  endtask

  task automatic update();
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
  endtask

  // Shift n bits of val LSB-first, checking tdo against exp_tdo before each shift.
  task automatic shift_word(input string tag, input logic [DR_W-1:0] val,
                            input int n, input logic [DR_W-1:0] exp_tdo);
    for (int i = 0; i < n; i++) begin
      check(tag, 64'(tdo), 64'(exp_tdo[i]));
      tdi = val[i]; shift_dr = 1'b1;
      tick();
      shift_dr = 1'b0;
    end
  endtask

  task automatic consume();
    upd_ready = 1'b1;
    tick();
    upd_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sel = 1'b1; sel_ir = 1'b0;
    capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0; update_ir = 1'b0;
    ir_in = '0; tdi = 1'b0; status_in = '0; upd_ready = 1'b0; err_clr = 1'b0;
    cap_data = {CAP2, CAP1, CAP0};
    tick(); tick();

    check("rst_tdo",       64'(tdo),       64'd0);
    check("rst_ir",        64'(ir),        64'd0);
    check("rst_ir_out",    64'(ir_out),    64'd0);
    check("rst_upd_valid", 64'(upd_valid), 64'd0);
    check("rst_upd_data",  64'(upd_data),  64'd0);
    check("rst_upd_ch",    64'(upd_ch),    64'd0);
    check("rst_overrun",   64'(overrun),   64'd0);
    check("rst_len_err",   64'(len_err),   64'd0);
    reset = 1'b0;

    // IR capture of status bits
    sel = 1'b0; sel_ir = 1'b1; status_in = 2'b10; capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0; sel_ir = 1'b0; sel = 1'b1;
    check("ir_out_cap", 64'(ir_out), 64'h2);

    // Channel 1, full 38-bit scan of ones
    load_ir(2'd1);
    check("ir_is_1", 64'(ir), 64'd1);
    capture();
    shift_word("ch1_tdo", {DR_W{1'b1}}, 38, CAP1);
    update();
    check("ch1_valid", 64'(upd_valid), 64'd1);
    check("ch1_data",  64'(upd_data),  64'h3F_FFFF_FFFF);
    check("ch1_ch",    64'(upd_ch),    64'd1);
    consume();
    check("ch1_drained", 64'(upd_valid), 64'd0);

    // Channel 0, length 16: capture masks the upper cap bits
    load_ir(2'd0);
    capture();
    shift_word("ch0_tdo", 38'h00FF, 16, 38'hA5C3);
    update();
    check("ch0_valid", 64'(upd_valid), 64'd1);
    check("ch0_data",  64'(upd_data),  64'h00FF);
    check("ch0_ch",    64'(upd_ch),    64'd0);
    consume();

    // Short scan gives a length error; err_clr racing a new error loses
    capture();
    shift_word("short_tdo", 38'h0, 15, 38'hA5C3);
    update();
    check("short_valid", 64'(upd_valid), 64'd0);
    check("short_len_err", 64'(len_err), 64'd1);
    capture();
    shift_word("short2_tdo", 38'h0, 15, 38'hA5C3);
    err_clr = 1'b1;
    update();
    err_clr = 1'b0;
    check("clr_vs_set", 64'(len_err), 64'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("len_err_clr", 64'(len_err), 64'd0);

    // Overrun: second update into an undrained slot is dropped
    capture();
    shift_word("ovr1_tdo", 38'h1234, 16, 38'hA5C3);
    update();
    capture();
    shift_word("ovr2_tdo", 38'hBEEF, 16, 38'hA5C3);
    update();
    check("ovr_valid",   64'(upd_valid), 64'd1);
    check("ovr_kept",    64'(upd_data),  64'h1234);
    check("ovr_flag",    64'(overrun),   64'd1);
    capture();
    shift_word("ovr3_tdo", 38'h5555, 16, 38'hA5C3);
    upd_ready = 1'b1; update_dr = 1'b1;
    tick();
    upd_ready = 1'b0; update_dr = 1'b0;
    check("refill_valid", 64'(upd_valid), 64'd1);
    check("refill_data",  64'(upd_data),  64'h5555);
    consume();
    check("refill_drained", 64'(upd_valid), 64'd0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("ovr_clr", 64'(overrun), 64'd0);

    // Capture in mid-scan holds sr but restarts the bit count
    capture();
    shift_word("pause_a_tdo", 38'h0, 4, 38'hA5C3);
    capture();
    shift_word("pause_b_tdo", 38'h0, 12, 38'h0A5C);
    update();
    check("pause_valid",   64'(upd_valid), 64'd0);
    check("pause_len_err", 64'(len_err),   64'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // Bypass: one-stage delay, no slot write and no length error
    load_ir(2'd3);
    check("ir_is_3", 64'(ir), 64'd3);
    capture();
    shift_word("byp_tdo", 38'b101, 3, 38'b010);
    check("byp_tdo_last", 64'(tdo), 64'd1);
    update();
    check("byp_valid",   64'(upd_valid), 64'd0);
    check("byp_len_err", 64'(len_err),   64'd0);

    // IR strobe without sel_ir is ignored
    ir_in = 2'd1; update_ir = 1'b1;
    tick();
    update_ir = 1'b0;
    check("ir_unsel", 64'(ir), 64'd3);

    // Reset mid-shift with a full slot and a sticky error
    load_ir(2'd0);
    capture();
    shift_word("pre_rst_tdo", 38'hFFFF, 16, 38'hA5C3);
    update();
    capture();
    shift_word("pre_rst2_tdo", 38'hFFFF, 16, 38'hA5C3);
    update();
    check("pre_rst_ovr", 64'(overrun), 64'd1);
    capture();
    shift_word("mid_tdo", 38'h1F, 5, 38'hA5C3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", 64'(upd_valid), 64'd0);
    check("mid_rst_data",  64'(upd_data),  64'd0);
    check("mid_rst_tdo",   64'(tdo),       64'd0);
    check("mid_rst_ir",    64'(ir),        64'd0);
    check("mid_rst_ovr",   64'(overrun),   64'd0);
    update();
    check("post_rst_valid", 64'(upd_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtag_debug_dr_bank.md
Name: jtag_debug_dr_bank

Overview:
Parametrised JTAG debug data-register bank. It succeeds the fixed 2-bit-IR / 38-bit-DR debug module and runs entirely in the system clock domain. TAP state strobes arrive already synchronised as one-cycle pulses. The bank selects one of NUM_CH data registers by IR, each with its own shift length, and captures, shifts and updates it. Updates go to the CPU-side debug logic through a valid/ready slot with overrun and length-error detection.

Parameters:
IR_W, 2, instruction register width.
NUM_CH, 4, number of implemented DRs (1..2**IR_W); IR codes >= NUM_CH select a 1-bit bypass.
DR_W, 38, maximum DR length and width of the data buses.
CH_LEN, {6'd16,6'd38,6'd38,6'd36}, packed per-channel lengths, 6 bits each (channel 0 in the LSBs), each 1..DR_W.
CNT_W, 7, width of the shift-bit counter.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sel  in  1  node selected for DR access (ena & ~usr1 equivalent)
sel_ir  in  1  node selected for IR access (ena & usr1 equivalent)
capture_dr  in  1  one-cycle pulse
shift_dr  in  1  one-cycle pulse, one per TCK shift edge
update_dr  in  1  one-cycle pulse
update_ir  in  1  one-cycle pulse
ir_in  in  IR_W  IR value presented with update_ir
tdi  in  1  serial in, valid with shift_dr
tdo  out  1  serial out = sr[0]
cap_data  in  NUM_CH*DR_W  capture values, channel c at bits [c*DR_W +: DR_W]
status_in  in  IR_W  status bits for IR capture
ir_out  out  IR_W  registered status_in
ir  out  IR_W  current instruction
upd_valid  out  1  update slot full
upd_ready  in  1  consumer accepts the slot
upd_data  out  DR_W  updated DR contents, bits >= channel length are zero
upd_ch  out  IR_W  channel of upd_data
overrun  out  1  sticky: update dropped because the slot was full
len_err  out  1  sticky: update with wrong bit count
err_clr  in  1  clears both sticky flags

Behaviour:
- Reset: sr, ir, ir_out, shift_cnt, upd_data, upd_ch = 0. upd_valid, overrun, len_err, in_between = 0.
- ir_out is loaded from status_in every cycle in which sel_ir & capture_dr.
- Event priority within one cycle: update_ir > update_dr > capture_dr > shift_dr. Only the highest-priority qualified event acts.
- update_ir & sel_ir: ir <= ir_in; in_between <= 0; shift_cnt <= 0.
- Effective length L = CH_LEN[ir] if ir < NUM_CH, else 1 (bypass).
- capture_dr & sel & ~in_between:
  - Implemented channel: sr <= cap_data slice of ir with bits >= L forced to 0.
  - Bypass: sr <= 0.
  - In all cases shift_cnt <= 0.
- capture_dr while in_between = 1: sr is held and shift_cnt is still cleared. This protects shifted-in data across a pause with no update.
- shift_dr & sel:
  - sr <= right shift; tdi enters at bit L-1; bits >= L stay 0.
  - shift_cnt increments, saturating at 2**CNT_W-1.
  - in_between <= 1.
- update_dr & sel: in_between <= 0.
  - Bypass IR: no other effect.
  - shift_cnt != L: no slot write; len_err <= 1.
  - shift_cnt == L, slot empty or (upd_valid & upd_ready) this cycle: upd_data <= sr, upd_ch <= ir, upd_valid <= 1. upd_valid is visible the cycle after the strobe.
  - shift_cnt == L, slot full and not being accepted: new data dropped, slot unchanged, overrun <= 1.
- Handshake: upd_valid & upd_ready consumes the slot (upd_valid <= 0) unless a refill happens in the same cycle. upd_data and upd_ch are stable while upd_valid = 1.
- err_clr clears both flags. If err_clr coincides with a new error, the set wins.
- Strobes with sel = 0 (or sel_ir = 0 for IR) have no effect.
- Reset mid-shift discards sr and the slot; no update is issued.

Decomposition:
- Package jtag_dbg_pkg:
  - CH_LEN field width constant (6).
  - function ch_len(packed, idx).
  - function len_mask(L) returning a DR_W-bit mask.
  - typedef for event priority encoding.
- Sub-module jtag_dbg_update_slot: one-entry valid/ready buffer carrying data and channel, with overrun output.

Test Plan:
- IR=1 (L=38); capture cap_data ch1 = 38'h2_1234_5678; 38 shifts of tdi=1 -> tdo sequence 0x21234 5678 LSB-first; after update_dr: upd_valid=1, upd_data=38'h3F_FFFF_FFFF, upd_ch=1.
- IR=0 (L=16), cap = 16'hA5C3 with upper cap bits all 1 -> sr[37:16]=0; 16 shifts of 16'h00FF -> upd_data = 38'h00FF.
- IR=0, 15 shifts then update_dr -> no upd_valid, len_err=1; err_clr -> len_err=0.
- Two valid updates with upd_ready=0 -> first data retained, overrun=1. Third update in the same cycle as upd_ready=1 -> new data accepted, upd_valid stays 1.
- Shift 4 bits, capture_dr without update, then finish shifting -> sr not reloaded (in_between); shift_cnt restarts so the update gives len_err.
- IR=3 with NUM_CH=3 (bypass): a 1-cycle tdi->tdo delay is observed and update_dr produces no slot write. Reset during shift -> all outputs 0 the next cycle.
